// File: rtl/rbm_vote_controller_pkg.sv
// rtl/rbm_vote_controller_pkg.sv - shared configuration for the RBM vote controller
// Purpose: default widths, FSM state encoding and the per-class packed-field accessor.
// Ports: none (package).
package rbm_vote_controller_pkg;

  localparam int OUT_DIM_DEF = 10;
  localparam int CNT_W_DEF   = 12;
  localparam int ITER_W_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } vote_state_e;

  // Low bit of class idx inside a packed vector of width-bit fields.
  function automatic int field_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rbm_vote_argmax.sv
// rtl/rbm_vote_argmax.sv - combinational top-1/top-2 search over packed counters
// Purpose: find the largest counter (lowest index on ties) and the runner-up value.
// Ports:
//   counts_i     in  OUT_DIM*CNT_W  packed counters, class i at [i*CNT_W +: CNT_W]
//   max_idx_o    out IDX_W          index of the largest counter
//   max_val_o    out CNT_W          largest counter value
//   second_val_o out CNT_W          second largest value (equals max on a tie)
module rbm_vote_argmax
  import rbm_vote_controller_pkg::*;
#(
  parameter int OUT_DIM = OUT_DIM_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int IDX_W   = $clog2(OUT_DIM)
) (
  input  logic [OUT_DIM*CNT_W-1:0] counts_i,
  output logic [IDX_W-1:0]         max_idx_o,
  output logic [CNT_W-1:0]         max_val_o,
  output logic [CNT_W-1:0]         second_val_o
);

  logic [CNT_W-1:0] val;

  always_comb begin
    max_idx_o    = '0;
    max_val_o    = counts_i[CNT_W-1:0];
    second_val_o = '0;
    val          = '0;
    for (int i = 1; i < OUT_DIM; i++) begin
      val = counts_i[field_lo(i, CNT_W) +: CNT_W];
      // Strict '>' keeps the lowest index on ties; a tied value then lands
      // in second_val so the lead becomes zero.
      if (val > max_val_o) begin
        second_val_o = max_val_o;
        max_val_o    = val;
        max_idx_o    = IDX_W'(i);
      end else if (val > second_val_o) begin
        second_val_o = val;
      end
    end
  end

endmodule

// File: rtl/rbm_vote_controller.sv
// rtl/rbm_vote_controller.sv - iteration and vote controller for the RBM inference chain
// Purpose: rerun the hidden/classify layers, accumulate saturating per-class votes,
//          stop on iteration limit or on a programmable lead, report the winner.
// Ports:
//   clock_i        in  1              system clock
//   reset_i        in  1              synchronous active-high reset
//   start_i        in  1              run request, accepted in IDLE or DONE
//   iter_limit_i   in  ITER_W         iterations to run (0 runs once)
//   margin_i       in  CNT_W          early-stop lead (0 disables)
//   layer_reset_o  out 1              reset to both RBM layers
//   sample_valid_i in  1              classify-layer finish strobe
//   sample_i       in  OUT_DIM        classify bits, bit i = class i
//   counts_o       out OUT_DIM*CNT_W  vote counters
//   winner_o       out IDX_W          registered argmax
//   iter_done_o    out ITER_W         completed iterations
//   busy_o         out 1              high in WAIT and EVAL
//   done_o         out 1              high in DONE
//   early_stop_o   out 1              run ended on margin
module rbm_vote_controller
  import rbm_vote_controller_pkg::*;
#(
  parameter int OUT_DIM = OUT_DIM_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int ITER_W  = ITER_W_DEF,
  parameter int IDX_W   = $clog2(OUT_DIM)
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [ITER_W-1:0]        iter_limit_i,
  input  logic [CNT_W-1:0]         margin_i,
  output logic                     layer_reset_o,
  input  logic                     sample_valid_i,
  input  logic [OUT_DIM-1:0]       sample_i,
  output logic [OUT_DIM*CNT_W-1:0] counts_o,
  output logic [IDX_W-1:0]         winner_o,
  output logic [ITER_W-1:0]        iter_done_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     early_stop_o
);

  vote_state_e              state_q, state_d;
  logic [ITER_W-1:0]        limit_q, limit_d;
  logic [CNT_W-1:0]         margin_q, margin_d;
  logic [OUT_DIM*CNT_W-1:0] counts_q, counts_d;
  logic [ITER_W-1:0]        iter_q, iter_d;
  logic [IDX_W-1:0]         winner_q, winner_d;
  logic                     early_q, early_d;

  logic [IDX_W-1:0] top_idx;
  logic [CNT_W-1:0] top_val;
  logic [CNT_W-1:0] second_val;
  logic [CNT_W-1:0] lead;

  rbm_vote_argmax #(
    .OUT_DIM (OUT_DIM),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) u_argmax (
    .counts_i     (counts_q),
    .max_idx_o    (top_idx),
    .max_val_o    (top_val),
    .second_val_o (second_val)
  );

  assign lead = top_val - second_val;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      limit_q  <= '0;
      margin_q <= '0;
      counts_q <= '0;
      iter_q   <= '0;
      winner_q <= '0;
      early_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      limit_q  <= limit_d;
      margin_q <= margin_d;
      counts_q <= counts_d;
      iter_q   <= iter_d;
      winner_q <= winner_d;
      early_q  <= early_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    limit_d       = limit_q;
    margin_d      = margin_q;
    counts_d      = counts_q;
    iter_d        = iter_q;
    winner_d      = winner_q;
    early_d       = early_q;
    layer_reset_o = 1'b1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          limit_d  = (iter_limit_i == '0) ? ITER_W'(1) : iter_limit_i;
          margin_d = margin_i;
          counts_d = '0;
          iter_d   = '0;
          winner_d = '0;
          early_d  = 1'b0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        layer_reset_o = 1'b0;
        if (sample_valid_i) begin
          for (int i = 0; i < OUT_DIM; i++) begin
            if (sample_i[i] && (counts_q[field_lo(i, CNT_W) +: CNT_W] != {CNT_W{1'b1}})) begin
              counts_d[field_lo(i, CNT_W) +: CNT_W] =
                counts_q[field_lo(i, CNT_W) +: CNT_W] + CNT_W'(1);
            end
          end
          iter_d  = iter_q + ITER_W'(1);
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        winner_d = top_idx;
        // Reaching the limit wins over the margin so early_stop only flags
        // runs that genuinely ended ahead of schedule.
        if (iter_q == limit_q) begin
          state_d = ST_DONE;
        end else if ((margin_q != '0) && (lead >= margin_q)) begin
          early_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign counts_o     = counts_q;
  assign winner_o     = winner_q;
  assign iter_done_o  = iter_q;
  assign busy_o       = (state_q == ST_WAIT) || (state_q == ST_EVAL);
  assign done_o       = (state_q == ST_DONE);
  assign early_stop_o = early_q;

endmodule

// File: tb/tb_rbm_vote_controller.sv
// tb/tb_rbm_vote_controller.sv - directed self-checking bench for rbm_vote_controller
module tb_rbm_vote_controller;

  localparam int OUT_DIM = 10;
  localparam int CNT_W   = 12;
  localparam int ITER_W  = 10;
  localparam int IDX_W   = 4;
  localparam int SAT_W   = 3;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     start;
  logic [ITER_W-1:0]        iter_limit;
  logic [CNT_W-1:0]         margin;
  logic                     sample_valid;
  logic [OUT_DIM-1:0]       sample;

  logic                     layer_reset;
  logic [OUT_DIM*CNT_W-1:0] counts;
  logic [IDX_W-1:0]         winner;
  logic [ITER_W-1:0]        iter_done;
  logic                     busy, done, early_stop;

  logic                     layer_reset_s;
  logic [OUT_DIM*SAT_W-1:0] counts_s;
  logic [IDX_W-1:0]         winner_s;
  logic [ITER_W-1:0]        iter_done_s;
  logic                     busy_s, done_s, early_stop_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  rbm_vote_controller #(
    .OUT_DIM(OUT_DIM), .CNT_W(CNT_W), .ITER_W(ITER_W), .IDX_W(IDX_W)
  ) dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .iter_limit_i(iter_limit),
    .margin_i(margin), .layer_reset_o(layer_reset), .sample_valid_i(sample_valid),
    .sample_i(sample), .counts_o(counts), .winner_o(winner), .iter_done_o(iter_done),
    .busy_o(busy), .done_o(done), .early_stop_o(early_stop)
  );

  // Narrow-counter instance sharing the same stimulus, checked for saturation.
  rbm_vote_controller #(
    .OUT_DIM(OUT_DIM), .CNT_W(SAT_W), .ITER_W(ITER_W), .IDX_W(IDX_W)
  ) dut_sat (
    .clock_i(clock), .reset_i(reset), .start_i(start), .iter_limit_i(iter_limit),
    .margin_i(margin[SAT_W-1:0]), .layer_reset_o(layer_reset_s),
    .sample_valid_i(sample_valid), .sample_i(sample), .counts_o(counts_s),
    .winner_o(winner_s), .iter_done_o(iter_done_s), .busy_o(busy_s),
    .done_o(done_s), .early_stop_o(early_stop_s)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OUT_DIM*CNT_W-1:0] one_cnt(input int idx, input int val);
    logic [OUT_DIM*CNT_W-1:0] v;
    v = '0;
    v[idx*CNT_W +: CNT_W] = CNT_W'(val);
    return v;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_start(input int lim, input int mar);
    iter_limit = ITER_W'(lim);
    margin     = CNT_W'(mar);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Drives one sample; returns at the negedge where the DUT sits in EVAL.
  task automatic do_sample(input logic [OUT_DIM-1:0] bits);
    sample_valid = 1'b1;
    sample       = bits;
    tick();
    sample_valid = 1'b0;
    sample       = '0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; iter_limit = '0; margin = '0;
    sample_valid = 1'b0; sample = '0;
    tick(); tick();

    // Reset state
    check("rst_layer_reset", layer_reset, 1);
    check("rst_counts", counts, 0);
    check("rst_winner", winner, 0);
    check("rst_iter_done", iter_done, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_early", early_stop, 0);
    reset = 1'b0;
    tick();

    // Three samples of class 7, limit 3, no margin
    do_start(3, 0);
    check("t2_busy", busy, 1);
    check("t2_lr_wait", layer_reset, 0);
    for (int k = 0; k < 3; k++) begin
      do_sample(10'b0010000000);
      check("t2_lr_eval", layer_reset, 1);
      check("t2_done_eval", done, 0);
      tick();
      if (k < 2) check("t2_lr_back", layer_reset, 0);
    end
    check("t2_counts", counts, one_cnt(7, 3));
    check("t2_winner", winner, 7);
    check("t2_iter", iter_done, 3);
    check("t2_done", done, 1);
    check("t2_early", early_stop, 0);
    check("t2_busy_end", busy, 0);

    // Early stop on margin 2 after two class-4 votes; start issued from DONE
    do_start(100, 2);
    check("t3_done_drop", done, 0);
    check("t3_counts_clr", counts, 0);
    do_sample(10'b0000010000); tick();
    check("t3_not_done", done, 0);
    do_sample(10'b0000010000); tick();
    check("t3_done", done, 1);
    check("t3_early", early_stop, 1);
    check("t3_iter", iter_done, 2);
    check("t3_winner", winner, 4);

    // Tie between classes 2 and 5
    do_start(1, 0);
    do_sample(10'b0000100100); tick();
    check("t4_counts", counts, one_cnt(2, 1) | one_cnt(5, 1));
    check("t4_winner", winner, 2);
    check("t4_done", done, 1);

    // Limit 0 runs exactly one (all-zero) iteration
    do_start(0, 0);
    do_sample(10'b0000000000); tick();
    check("t4z_done", done, 1);
    check("t4z_iter", iter_done, 1);
    check("t4z_counts", counts, 0);

    // Saturation on the 3-bit instance
    do_start(10, 0);
    for (int k = 0; k < 10; k++) begin
      do_sample(10'b0000000001); tick();
    end
    check("t5_sat_counts", counts_s, 7);
    check("t5_sat_iter", iter_done_s, 10);
    check("t5_sat_done", done_s, 1);
    check("t5_wide_counts", counts, one_cnt(0, 10));

    // Reset in WAIT after one sample
    do_start(5, 0);
    do_sample(10'b0000000010); tick();
    check("t6_pre_rst_cnt", counts, one_cnt(1, 1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_lr", layer_reset, 1);
    check("t6_counts", counts, 0);
    check("t6_iter", iter_done, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_winner", winner, 0);
    tick();
    check("t6_idle_busy", busy, 0);

    // sample_valid during EVAL ignored; start during WAIT ignored
    do_start(2, 0);
    sample_valid = 1'b1; sample = 10'b0000001000;
    tick();
    tick();
    sample_valid = 1'b0; sample = '0;
    check("t7_cnt_eval_ign", counts, one_cnt(3, 1));
    check("t7_iter_eval_ign", iter_done, 1);
    iter_limit = 10'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t7_still_busy", busy, 1);
    do_sample(10'b0000001000); tick();
    check("t7_done", done, 1);
    check("t7_iter", iter_done, 2);
    check("t7_counts", counts, one_cnt(3, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
